// File: rtl/whack_pkg.sv
// Shared types and helpers for the box-hitting game engine.
package whack_pkg;

    typedef enum logic [1:0] {
        LOBBY     = 2'd0,
        ARM       = 2'd1,
        PLAY      = 2'd2,
        GAME_OVER = 2'd3
    } state_e;

    localparam int BOX_NONE = 0;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] value);
        return (value == 32'd0) ? 32'd0 : value - 32'd1;
    endfunction

endpackage

// File: rtl/game_tick_gen.sv
// One-cycle "game second" strobe every TICK_DIV clocks; held at zero while cleared.
module game_tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = enable && !clear && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/whack_score_engine.sv
// Game-round engine: picks targets, scores presses, runs the round and target
// countdowns, and drives the lobby/hit sound enables.
module whack_score_engine
    import whack_pkg::*;
#(
    parameter int NUM_BOXES      = 7,
    parameter int AW             = 3,
    parameter int SCORE_W        = 11,
    parameter int TIMER_W        = 7,
    parameter int TICK_DIV       = 50000000,
    parameter int ROUND_SECONDS  = 60,
    parameter int TARGET_SECONDS = 3,
    parameter int PENALTY_EN     = 1,
    parameter int SOUND_CYCLES   = 5000000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start_game,
    input  logic [AW-1:0]      box_address,
    input  logic [AW-1:0]      lfsr_value,
    output logic [AW-1:0]      mif_control_signal,
    output logic [SCORE_W-1:0] score,
    output logic [TIMER_W-1:0] game_timer,
    output logic [7:0]         miss_count,
    output logic               play_sound,
    output logic               lobby_sound,
    output logic               game_over
);

    localparam int SND_W = $clog2(SOUND_CYCLES + 1);
    localparam int TT_W  = $clog2(TARGET_SECONDS + 1);

    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [TIMER_W-1:0] ROUND_INIT = TIMER_W'(ROUND_SECONDS);
    localparam logic [TT_W-1:0]    TT_LAST    = TT_W'(TARGET_SECONDS - 1);
    localparam logic [SND_W-1:0]   SND_INIT   = SND_W'(SOUND_CYCLES);
    localparam logic [AW-1:0]      NONE       = AW'(BOX_NONE);

    state_e             state_q, state_d;
    logic [AW-1:0]      s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
    logic [AW-1:0]      target_q, target_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         miss_q, miss_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [TT_W-1:0]    tgt_tmr_q, tgt_tmr_d;
    logic [SND_W-1:0]   snd_q, snd_d;
    logic               rearm_q, rearm_d;

    logic               tick, tick_en, tick_clr;
    logic               press, hit, timeout, round_end, begin_round;
    int                 cand_i;
    logic [AW-1:0]      cand;

    game_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (CLOCK_50),
        .reset  (reset),
        .enable (tick_en),
        .clear  (tick_clr),
        .tick   (tick)
    );

    // Event decode from the synchronised box code and the tick strobe
    always_comb begin
        tick_en     = (state_q == ARM) || (state_q == PLAY);
        tick_clr    = !tick_en;
        press       = (s2_q != NONE) && (prev_q == NONE);
        hit         = press && (s2_q == target_q);
        timeout     = tick && (tgt_tmr_q == TT_LAST);
        round_end   = tick && (timer_q <= TIMER_W'(1));
        begin_round = start_game &&
                      ((state_q == LOBBY) || ((state_q == GAME_OVER) && rearm_q));
        // Never redraw the box that was just up, so the player always has to move
        cand_i = (int'(lfsr_value) % NUM_BOXES) + 1;
        if ((NUM_BOXES > 1) && (cand_i == int'(target_q))) begin
            cand_i = (cand_i % NUM_BOXES) + 1;
        end
        cand = AW'(cand_i);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= LOBBY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        s1_d      = box_address;
        s2_d      = s1_q;
        prev_d    = s2_q;
        target_d  = target_q;
        score_d   = score_q;
        miss_d    = miss_q;
        timer_d   = timer_q;
        tgt_tmr_d = tgt_tmr_q;
        snd_d     = (snd_q != '0) ? snd_q - SND_W'(1) : snd_q;
        rearm_d   = rearm_q;

        case (state_q)
            LOBBY: begin
                target_d = NONE;
            end
            ARM: begin
                if (tick) begin
                    timer_d = TIMER_W'(sat_dec(32'(timer_q)));
                end
                if (!round_end) begin
                    target_d  = cand;
                    tgt_tmr_d = '0;
                    state_d   = PLAY;
                end
            end
            PLAY: begin
                if (tick) begin
                    timer_d   = TIMER_W'(sat_dec(32'(timer_q)));
                    tgt_tmr_d = tgt_tmr_q + TT_W'(1);
                end
                if (round_end) begin
                    state_d = GAME_OVER;
                end else if (hit) begin
                    score_d = SCORE_W'(sat_inc(32'(score_q), 32'(SCORE_MAX)));
                    snd_d   = SND_INIT;
                    state_d = ARM;
                end else begin
                    if (press) begin
                        miss_d = 8'(sat_inc(32'(miss_d), 32'd255));
                        if (PENALTY_EN != 0) begin
                            score_d = SCORE_W'(sat_dec(32'(score_q)));
                        end
                    end
                    if (timeout) begin
                        miss_d  = 8'(sat_inc(32'(miss_d), 32'd255));
                        state_d = ARM;
                    end
                end
            end
            GAME_OVER: begin
                target_d = NONE;
                // A held start key must be released before it can restart the game
                if (!start_game) begin
                    rearm_d = 1'b1;
                end
            end
        endcase

        if (round_end) begin
            state_d  = GAME_OVER;
            target_d = NONE;
            timer_d  = '0;
            snd_d    = '0;
            rearm_d  = 1'b0;
        end

        if (begin_round) begin
            score_d   = '0;
            miss_d    = '0;
            timer_d   = ROUND_INIT;
            tgt_tmr_d = '0;
            snd_d     = '0;
            rearm_d   = 1'b0;
            state_d   = ARM;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            prev_q    <= '0;
            target_q  <= '0;
            score_q   <= '0;
            miss_q    <= '0;
            timer_q   <= ROUND_INIT;
            tgt_tmr_q <= '0;
            snd_q     <= '0;
            rearm_q   <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            prev_q    <= prev_d;
            target_q  <= target_d;
            score_q   <= score_d;
            miss_q    <= miss_d;
            timer_q   <= timer_d;
            tgt_tmr_q <= tgt_tmr_d;
            snd_q     <= snd_d;
            rearm_q   <= rearm_d;
        end
    end

    always_comb begin
        mif_control_signal = ((state_q == ARM) || (state_q == PLAY)) ? target_q : NONE;
        score              = score_q;
        game_timer         = timer_q;
        miss_count         = miss_q;
        play_sound         = (snd_q != '0);
        lobby_sound        = (state_q == LOBBY);
        game_over          = (state_q == GAME_OVER);
    end

endmodule

// File: tb/tb_whack_score_engine.sv
// Directed bench for whack_score_engine with a small, fast-ticking configuration.
module tb_whack_score_engine;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        start_game;
    logic [2:0]  box_address;
    logic [2:0]  lfsr_value;
    logic [2:0]  mif_control_signal;
    logic [10:0] score;
    logic [6:0]  game_timer;
    logic [7:0]  miss_count;
    logic        play_sound;
    logic        lobby_sound;
    logic        game_over;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    whack_score_engine #(
        .NUM_BOXES      (4),
        .AW             (3),
        .SCORE_W        (11),
        .TIMER_W        (7),
        .TICK_DIV       (10),
        .ROUND_SECONDS  (3),
        .TARGET_SECONDS (2),
        .PENALTY_EN     (1),
        .SOUND_CYCLES   (4)
    ) dut (
        .CLOCK_50           (CLOCK_50),
        .reset              (reset),
        .start_game         (start_game),
        .box_address        (box_address),
        .lfsr_value         (lfsr_value),
        .mif_control_signal (mif_control_signal),
        .score              (score),
        .game_timer         (game_timer),
        .miss_count         (miss_count),
        .play_sound         (play_sound),
        .lobby_sound        (lobby_sound),
        .game_over          (game_over)
    );

    typedef struct {
        logic rst;
        logic st;
        int   box;
        int   lfsr;
        int   n;
        int   mif;
        int   sc;
        int   tmr;
        int   mi;
        int   ply;
        int   lob;
        int   go;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input int b, input int l, input int n,
                                input int m, input int sc, input int t, input int mi,
                                input int p, input int lo, input int g);
        vec_t v;
        v.rst = r;  v.st = s;    v.box = b;  v.lfsr = l; v.n = n;
        v.mif = m;  v.sc = sc;   v.tmr = t;  v.mi = mi;
        v.ply = p;  v.lob = lo;  v.go = g;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int m, input int sc, input int t, input int mi,
                             input int p, input int lo, input int g);
        chk({tag, ".mif"},   32'(mif_control_signal), 32'(m));
        chk({tag, ".score"}, 32'(score),              32'(sc));
        chk({tag, ".timer"}, 32'(game_timer),         32'(t));
        chk({tag, ".miss"},  32'(miss_count),         32'(mi));
        chk({tag, ".play"},  32'(play_sound),         32'(p));
        chk({tag, ".lobby"}, 32'(lobby_sound),        32'(lo));
        chk({tag, ".gover"}, 32'(game_over),          32'(g));
    endtask

    task automatic press(input string tag, input int code, input int exp_sc, input int exp_mi);
        box_address = 3'(code);
        step(3);
        chk({tag, ".score"}, 32'(score),      32'(exp_sc));
        chk({tag, ".miss"},  32'(miss_count), 32'(exp_mi));
        box_address = 3'd0;
        step(2);
    endtask

    initial begin
        reset       = 1'b1;
        start_game  = 1'b0;
        box_address = 3'd0;
        lfsr_value  = 3'd6;

        // First round: start, hit, retrigger hold, wrong presses, timeout, round end
        vecs.push_back(mk(1, 0, 0, 6, 1,  0, 0, 3, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 6, 1,  0, 0, 3, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 6, 1,  0, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 6, 1,  3, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3, 6, 2,  3, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3, 6, 1,  3, 1, 3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 3, 6, 2,  4, 1, 3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 6, 1,  4, 1, 3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 2, 6, 2,  4, 1, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2, 6, 1,  4, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 6, 2,  4, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2, 6, 2,  4, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2, 6, 1,  4, 0, 2, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 6, 4,  4, 0, 2, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 6, 1,  4, 0, 1, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  1, 0, 1, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8,  1, 0, 1, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 3, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            reset       = vecs[i].rst;
            start_game  = vecs[i].st;
            box_address = 3'(vecs[i].box);
            lfsr_value  = 3'(vecs[i].lfsr);
            for (int k = 0; k < vecs[i].n; k++) begin
                step(1);
                check_all($sformatf("v%0d.%0d", i, k), vecs[i].mif, vecs[i].sc, vecs[i].tmr,
                          vecs[i].mi, vecs[i].ply, vecs[i].lob, vecs[i].go);
            end
        end

        // Restart after release, then a correct press landing on the final tick
        lfsr_value = 3'd6;
        start_game = 1'b0;
        step(1);
        chk("rearm.gover", 32'(game_over), 32'd1);
        start_game = 1'b1;
        step(1);
        check_all("restart", 0, 0, 3, 0, 0, 0, 0);
        step(1);
        chk("b1.mif", 32'(mif_control_signal), 32'd3);
        step(11);
        box_address = 3'd3;
        step(2);
        chk("b14.score", 32'(score), 32'd0);
        step(1);
        chk("b15.score", 32'(score), 32'd1);
        chk("b15.play", 32'(play_sound), 32'd1);
        box_address = 3'd0;
        step(1);
        chk("b16.mif", 32'(mif_control_signal), 32'd4);
        step(4);
        chk("b20.timer", 32'(game_timer), 32'd1);
        chk("b20.miss", 32'(miss_count), 32'd0);
        step(7);
        box_address = 3'd4;
        step(2);
        chk("b29.gover", 32'(game_over), 32'd0);
        chk("b29.score", 32'(score), 32'd1);
        step(1);
        check_all("final_tick", 0, 1, 0, 0, 0, 0, 1);
        box_address = 3'd0;
        step(5);
        chk("held_start.gover", 32'(game_over), 32'd1);
        chk("held_start.score", 32'(score), 32'd1);
        start_game = 1'b0;
        step(1);
        chk("release.gover", 32'(game_over), 32'd1);
        start_game = 1'b1;
        step(1);
        check_all("restart2", 0, 0, 3, 0, 0, 0, 0);

        // Build score to 2, penalty from 2, back to 2, then reset mid-round
        press("c3", 3, 1, 0);
        press("c8", 4, 2, 0);
        box_address = 3'd2;
        step(3);
        chk("c13.score", 32'(score), 32'd1);
        chk("c13.miss", 32'(miss_count), 32'd1);
        chk("c13.mif", 32'(mif_control_signal), 32'd3);
        box_address = 3'd0;
        step(2);
        press("c18", 3, 2, 1);
        chk("c20.mif", 32'(mif_control_signal), 32'd4);
        chk("c20.timer", 32'(game_timer), 32'd1);
        chk("c20.play", 32'(play_sound), 32'd1);
        start_game = 1'b0;
        reset      = 1'b1;
        step(1);
        check_all("mid_reset", 0, 0, 3, 0, 0, 1, 0);
        reset = 1'b0;
        step(1);
        check_all("post_reset", 0, 0, 3, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
